// File: rtl/wb_arbiter_2m_if.sv
// wb_arbiter_2m_if: Wishbone classic bus bundle used on every port of
// wb_arbiter_2m.
//
// Signals (named from the bus master's point of view):
//   cyc, stb, we, sel[SW], adr[AW], dat_w[DW]  master -> slave
//   dat_r[DW], ack, err                        slave  -> master
//
// Modports:
//   master : drives the request side, receives the response side
//   slave  : receives the request side, drives the response side
//
// Valid/ready semantics: a beat is offered while cyc && stb are high. The
// request fields must hold steady until the slave answers with a single-cycle
// ack (or err). cyc held high across several beats keeps the bus locked to
// one master.
interface wb_arbiter_2m_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;

    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master, one-slave Wishbone classic arbiter.
//   Master 0 is the management SoC path; master 1 is the osiris_i core.
//   The owner keeps the slave bus for as long as its cyc stays high.
//   Responses (ack/err/read data) reach only the owner. Everyone else
//   sees zeros.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   m0, m1      wb_arbiter_2m_if.slave   (bus from each master)
//   s           wb_arbiter_2m_if.master  (bus to the shared slave)
//   grant_o     one-hot owner: bit0 = master 0, bit1 = master 1, 00 = idle
//   state_o     current arbiter state (IDLE=0, OWN0=1, OWN1=2), for debug
//
// Parameters:
//   AW, DW          address / data width (DW a multiple of 8)
//   ROUND_ROBIN     1: alternate on contention, 0: master 0 always wins
//   TIMEOUT_CYCLES  stall limit (1..1023), used only with WB_ARB_TIMEOUT_EN
//
// Optional feature, macro WB_ARB_TIMEOUT_EN:
//   A stall counter aborts an owner whose strobe goes unanswered for
//   TIMEOUT_CYCLES cycles. The owner gets a one-cycle err, with s.cyc and
//   s.stb held low in that cycle, and the arbiter then returns to IDLE.
//   When the macro is undefined, no counter is built and err is a plain
//   passthrough.
module wb_arbiter_2m #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_arbiter_2m_if.slave         m0,
    wb_arbiter_2m_if.slave         m1,
    wb_arbiter_2m_if.master        s,
    output logic [1:0]             grant_o,
    output logic [1:0]             state_o
);
    localparam int SW = DW / 8;

    generate
        if (DW % 8 != 0) begin : g_dw_check
            $error("wb_arbiter_2m: DW must be a multiple of 8");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_to_check
            $error("wb_arbiter_2m: TIMEOUT_CYCLES must be in 1..1023");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // Last winner: 0 = master 0, 1 = master 1. It resets to 1 so that
    // master 0 wins the first contention.
    logic   last_q, last_d;

    logic          own0;
    logic          own1;
    logic          cyc_mux;
    logic          stb_mux;
    logic          we_mux;
    logic [SW-1:0] sel_mux;
    logic [AW-1:0] adr_mux;
    logic [DW-1:0] dat_mux;
    logic          beat;
    logic          timeout;

    assign own0 = (state_q == OWN0);
    assign own1 = (state_q == OWN1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_CYCLES);

    logic [9:0] stall_q, stall_d;

    // The abort cycle is the one in which the count sits at the limit.
    assign timeout = (own0 | own1) && (stall_q == TO_LIMIT);

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE || timeout || s.ack || s.err) begin
            stall_d = '0;
        end else if (stb_mux && stall_q != TO_LIMIT) begin
            stall_d = stall_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. The grant is decided only in IDLE, so each handover
    // passes through exactly one dead cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    if (ROUND_ROBIN != 0 && !last_q) begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end
                end else if (m0.cyc) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (m1.cyc) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0.cyc || timeout) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                if (!m1.cyc || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Datapath: a pure combinational mux from the owner to the slave, and
    // responses gated back to the owner only. No registers, no added latency.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        sel_mux = '0;
        adr_mux = '0;
        dat_mux = '0;
        if (own0) begin
            cyc_mux = m0.cyc;
            stb_mux = m0.stb;
            we_mux  = m0.we;
            sel_mux = m0.sel;
            adr_mux = m0.adr;
            dat_mux = m0.dat_w;
        end else if (own1) begin
            cyc_mux = m1.cyc;
            stb_mux = m1.stb;
            we_mux  = m1.we;
            sel_mux = m1.sel;
            adr_mux = m1.adr;
            dat_mux = m1.dat_w;
        end

        // A slave response counts only while the owner has a live strobe.
        // Stray ack/err in IDLE or between beats is dropped.
        beat = cyc_mux & stb_mux;

        s.cyc   = cyc_mux & ~timeout;
        s.stb   = stb_mux & ~timeout;
        s.we    = we_mux;
        s.sel   = sel_mux;
        s.adr   = adr_mux;
        s.dat_w = dat_mux;

        m0.ack   = own0 & beat & s.ack & ~timeout;
        m0.err   = own0 & ((beat & s.err) | timeout);
        m0.dat_r = own0 ? s.dat_r : '0;

        m1.ack   = own1 & beat & s.ack & ~timeout;
        m1.err   = own1 & ((beat & s.err) | timeout);
        m1.dat_r = own1 ? s.dat_r : '0;

        grant_o = {own1, own0};
        state_o = state_q;
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed bench for wb_arbiter_2m.
// Instantiates a round-robin arbiter (with a simple slave model) and a
// fixed-priority arbiter (used only for grant order). Read data and ack
// owners go into exp_q when a beat is started. They are popped and compared
// when a master sees its ack.
module tb_wb_arbiter_2m;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m0_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) m1_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) s_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) fp_m0_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) fp_m1_if ();
    wb_arbiter_2m_if #(.AW(AW), .DW(DW)) fp_s_if ();

    logic [1:0] grant, state, fp_grant, fp_state;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant),
        .state_o (state)
    );

    wb_arbiter_2m #(.AW(AW), .DW(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TO)) dut_fp (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0      (fp_m0_if),
        .m1      (fp_m1_if),
        .s       (fp_s_if),
        .grant_o (fp_grant),
        .state_o (fp_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DW+1:0] exp_q[$];     // {ack owner one-hot, read data}
    logic [DW-1:0] rdata_q[$];   // data the slave model returns, in order
    int checks = 0;
    int errors = 0;

    // ---------------- slave model ----------------
    // Acks a beat slave_lat cycles after it becomes visible. The ack lasts
    // one cycle. stray_req forces an ack regardless of strobe.
    int slave_lat = 2;
    int cnt       = 0;
    bit stray_req = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_if.ack   = 1'b0;
            s_if.dat_r = '0;
            cnt        = 0;
        end else if (s_if.ack) begin
            s_if.ack   = 1'b0;
            s_if.dat_r = '0;
            cnt        = 0;
        end else if (stray_req) begin
            s_if.ack = 1'b1;
        end else if (s_if.cyc && s_if.stb) begin
            cnt++;
            if (cnt >= slave_lat) begin
                s_if.ack   = 1'b1;
                s_if.dat_r = (rdata_q.size() > 0) ? rdata_q.pop_front() : '0;
            end
        end else begin
            cnt = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        if (m == 0) begin
            m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
            m0_if.sel = 4'hF; m0_if.adr = adr; m0_if.dat_w = dat;
        end else begin
            m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
            m1_if.sel = 4'hF; m1_if.adr = adr; m1_if.dat_w = dat;
        end
    endtask

    // Waits (bounded) for an ack on any master and compares it with the
    // scoreboard head. On the cycles before the ack, the other master must
    // stay quiet.
    task automatic wait_ack(input int m, input string tag);
        int            n;
        bit            got;
        logic [1:0]    acks;
        logic [DW-1:0] dat;
        logic [DW+1:0] exp_v;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            acks = {m1_if.ack, m0_if.ack};
            if (acks != 2'b00) begin
                dat   = (m == 1) ? m1_if.dat_r : m0_if.dat_r;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check(tag, {acks, dat}, exp_v);
                got = 1'b1;
            end else if (m == 1) begin
                check({tag, "_m0_quiet"}, {m0_if.err, m0_if.dat_r}, '0);
            end else begin
                check({tag, "_m1_quiet"}, {m1_if.err, m1_if.dat_r}, '0);
            end
        end
        check({tag, "_seen"}, got, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        s_if.err = 1'b0;
        fp_m0_if.cyc = 0; fp_m0_if.stb = 0; fp_m0_if.we = 0; fp_m0_if.sel = '0;
        fp_m0_if.adr = '0; fp_m0_if.dat_w = '0;
        fp_m1_if.cyc = 0; fp_m1_if.stb = 0; fp_m1_if.we = 0; fp_m1_if.sel = '0;
        fp_m1_if.adr = '0; fp_m1_if.dat_w = '0;
        fp_s_if.ack = 0; fp_s_if.err = 0; fp_s_if.dat_r = '0;

        // Reset state, with master 0 actively requesting during reset.
        tick();
        drive(0, 1, 1, 1, 32'h1234_5678, 32'hCAFE_F00D);
        tick();
        check("rst_grant", grant, 2'b00);
        check("rst_state", state, 2'b00);
        check("rst_s_ctl", {s_if.cyc, s_if.stb, s_if.we, s_if.sel}, '0);
        check("rst_s_adr", s_if.adr, '0);
        check("rst_s_dat", s_if.dat_w, '0);
        check("rst_m0_rsp", {m0_if.ack, m0_if.err, m0_if.dat_r}, '0);
        drive(0, 0, 0, 0, '0, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write from master 0.
        exp_q.push_back({2'b01, 32'h0});
        drive(0, 1, 1, 1, 32'h3000_0004, 32'hDEAD_BEEF);
        check("wr_pre_scyc", s_if.cyc, 0);
        tick();
        check("wr_grant", grant, 2'b01);
        check("wr_s_ctl", {s_if.cyc, s_if.stb, s_if.we, s_if.sel}, 7'b111_1111);
        check("wr_s_adr", s_if.adr, 32'h3000_0004);
        check("wr_s_dat", s_if.dat_w, 32'hDEAD_BEEF);
        wait_ack(0, "wr_ack");
        drive(0, 0, 0, 0, '0, '0);
        tick();

        // Stray ack while idle reaches nobody.
        stray_req = 1'b1;
        tick();
        check("stray_idle", {s_if.ack, m0_if.ack, m1_if.ack}, 3'b100);
        stray_req = 1'b0;
        tick();

        // Round-robin contention right after reset: m0, dead cycle, m1, then m0.
        pulse_reset();
        exp_q.push_back({2'b01, 32'hA0}); rdata_q.push_back(32'hA0);
        exp_q.push_back({2'b10, 32'hB0}); rdata_q.push_back(32'hB0);
        drive(0, 1, 1, 0, 32'h100, '0);
        drive(1, 1, 1, 0, 32'h200, '0);
        tick();
        check("rr_first_grant", grant, 2'b01);
        check("rr_first_adr", s_if.adr, 32'h100);
        wait_ack(0, "rr_m0");
        drive(0, 0, 0, 0, '0, '0);
        tick();
        check("rr_dead_cycle", {grant, s_if.cyc}, 3'b000);
        tick();
        check("rr_handover", grant, 2'b10);
        check("rr_handover_adr", s_if.adr, 32'h200);
        wait_ack(1, "rr_m1");
        drive(1, 0, 0, 0, '0, '0);
        tick();
        exp_q.push_back({2'b01, 32'hA1}); rdata_q.push_back(32'hA1);
        exp_q.push_back({2'b10, 32'hB1}); rdata_q.push_back(32'hB1);
        drive(0, 1, 1, 0, 32'h104, '0);
        drive(1, 1, 1, 0, 32'h204, '0);
        tick();
        check("rr_second_grant", grant, 2'b01);
        wait_ack(0, "rr2_m0");
        drive(0, 0, 0, 0, '0, '0);
        wait_ack(1, "rr2_m1");
        drive(1, 0, 0, 0, '0, '0);
        tick();

        // Fixed priority: master 0 wins every contention.
        for (int r = 0; r < 3; r++) begin
            fp_m0_if.cyc = 1; fp_m0_if.stb = 1;
            fp_m1_if.cyc = 1; fp_m1_if.stb = 1;
            tick();
            check($sformatf("fp_round%0d_grant", r), fp_grant, 2'b01);
            fp_m0_if.cyc = 0; fp_m0_if.stb = 0;
            fp_m1_if.cyc = 0; fp_m1_if.stb = 0;
            tick();
            check($sformatf("fp_round%0d_idle", r), fp_grant, 2'b00);
        end

        // Master 1 four-beat read burst; master 0 requests after beat 1.
        rdata_q.push_back(32'h11); rdata_q.push_back(32'h22);
        rdata_q.push_back(32'h33); rdata_q.push_back(32'h44);
        rdata_q.push_back(32'h55);
        exp_q.push_back({2'b10, 32'h11}); exp_q.push_back({2'b10, 32'h22});
        exp_q.push_back({2'b10, 32'h33}); exp_q.push_back({2'b10, 32'h44});
        drive(1, 1, 1, 0, 32'h400, '0);
        tick();
        check("burst_grant", grant, 2'b10);
        wait_ack(1, "burst_b0");
        drive(0, 1, 1, 0, 32'h500, '0);
        exp_q.push_back({2'b01, 32'h55});
        for (int b = 1; b < 4; b++) begin
            drive(1, 1, 1, 0, 32'h400 + 32'(4 * b), '0);
            wait_ack(1, $sformatf("burst_b%0d", b));
            check($sformatf("burst_b%0d_hold", b), grant, 2'b10);
        end
        drive(1, 0, 0, 0, '0, '0);
        wait_ack(0, "after_burst_m0");
        drive(0, 0, 0, 0, '0, '0);
        tick();

        // Reset in the middle of a master 1 transfer.
        slave_lat = 50;
        drive(1, 1, 1, 0, 32'h600, '0);
        tick();
        check("midrst_grant", grant, 2'b10);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_grant0", {grant, state}, 4'b0000);
        check("midrst_s_ctl", {s_if.cyc, s_if.stb, s_if.adr}, '0);
        check("midrst_m1_rsp", {m1_if.ack, m1_if.err, m1_if.dat_r}, '0);
        drive(1, 0, 0, 0, '0, '0);
        tick();
        rst_n = 1'b1;
        slave_lat = 2;
        exp_q.push_back({2'b01, 32'hC0}); rdata_q.push_back(32'hC0);
        exp_q.push_back({2'b10, 32'hC1}); rdata_q.push_back(32'hC1);
        drive(0, 1, 1, 0, 32'h700, '0);
        drive(1, 1, 1, 0, 32'h704, '0);
        tick();
        check("postrst_grant", grant, 2'b01);
        wait_ack(0, "postrst_m0");
        drive(0, 0, 0, 0, '0, '0);
        wait_ack(1, "postrst_m1");
        drive(1, 0, 0, 0, '0, '0);
        tick();

        // Stray ack while the owner holds cyc with stb low is dropped.
        drive(0, 1, 0, 0, 32'h800, '0);
        tick();
        check("stbl_grant", grant, 2'b01);
        stray_req = 1'b1;
        tick();
        check("stbl_stray", {s_if.ack, m0_if.ack, m0_if.err, m1_if.ack}, 4'b1000);
        stray_req = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        tick();
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // The slave never answers; master 0 must be aborted with one err.
        slave_lat = 1000;
        drive(0, 1, 1, 0, 32'h900, '0);
        tick();
        check("to_grant", grant, 2'b01);
        drive(1, 1, 1, 0, 32'h904, '0);
        n = 0;
        while (!m0_if.err && n < 30) begin
            tick();
            n++;
        end
        check("to_cycles", n, TO);
        check("to_err_cycle", {m0_if.err, m0_if.ack, s_if.cyc, s_if.stb}, 4'b1000);
        drive(0, 0, 0, 0, '0, '0);
        tick();
        check("to_err_once", {m0_if.err, grant}, 3'b000);
        slave_lat = 2;
        exp_q.push_back({2'b10, 32'hD1}); rdata_q.push_back(32'hD1);
        tick();
        check("to_next_grant", grant, 2'b10);
        wait_ack(1, "to_m1");
        drive(1, 0, 0, 0, '0, '0);
        tick();
`else
        // Without the timeout, err is a direct passthrough to the owner.
        slave_lat = 50;
        drive(0, 1, 1, 0, 32'h900, '0);
        tick();
        check("errpt_grant", grant, 2'b01);
        s_if.err = 1'b1;
        #1;
        check("errpt_route", {m0_if.err, m1_if.err}, 2'b10);
        s_if.err = 1'b0;
        drive(0, 0, 0, 0, '0, '0);
        tick();
        tick();
        slave_lat = 2;
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
